// File: rtl/fetch_stage.sv
// Y86 fetch stage: predicted-PC register, byte-wide instruction memory,
// instruction split/length/next-PC prediction and the F/D pipeline register.
module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        bubble_d,
    input  logic        mispred,
    input  logic [31:0] mispred_pc,
    input  logic        ret_done,
    input  logic [31:0] ret_pc,
    output logic [31:0] f_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [31:0] D_valC,
    output logic [31:0] D_valP
);

    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [32:0] MEM_LIMIT = 33'(IMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [31:0] valC;
        logic [31:0] valP;
    } fdT;

    localparam fdT BUBBLE = '{
        stat: STAT_AOK, icode: 4'h1, ifun: 4'h0,
        rA: 4'hF, rB: 4'hF, valC: 32'h0, valP: 32'h0
    };

    logic [7:0]  imem [IMEM_BYTES];
    logic [31:0] predPC;
    logic [31:0] predNext;
    fdT          fd;
    fdT          fetched;

    logic [32:0] pc33;
    logic [32:0] lastAddr;
    logic [32:0] cBase;
    logic [7:0]  byte0;
    logic [7:0]  regByte;
    logic [3:0]  icode;
    logic        needRegids;
    logic        needValC;
    logic        memErr;
    logic [2:0]  len;
    logic [31:0] valC;

    // Out-of-range bytes read as zero; memErr flags them separately.
    function automatic logic [7:0] readByte(input logic [32:0] addr);
        return (addr < MEM_LIMIT) ? imem[addr[AW-1:0]] : 8'h00;
    endfunction

    always_comb begin
        if (mispred)
            f_pc = mispred_pc;
        else if (ret_done)
            f_pc = ret_pc;
        else
            f_pc = predPC;
    end

    always_comb begin
        pc33  = {1'b0, f_pc};
        byte0 = readByte(pc33);
        icode = byte0[7:4];
        unique case (icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: needRegids = 1'b1;
            default:                                  needRegids = 1'b0;
        endcase
        unique case (icode)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: needValC = 1'b1;
            default:                      needValC = 1'b0;
        endcase
        len      = 3'd1 + {2'b0, needRegids} + (needValC ? 3'd4 : 3'd0);
        lastAddr = pc33 + 33'(len) - 33'd1;
        memErr   = lastAddr >= MEM_LIMIT;
        regByte  = readByte(pc33 + 33'd1);
        cBase    = pc33 + 33'd1 + 33'(needRegids);
        valC     = 32'h0;
        if (needValC)
            valC = {readByte(cBase + 33'd3), readByte(cBase + 33'd2),
                    readByte(cBase + 33'd1), readByte(cBase)};
    end

    always_comb begin
        fetched.stat  = STAT_AOK;
        fetched.icode = icode;
        fetched.ifun  = byte0[3:0];
        fetched.rA    = needRegids ? regByte[7:4] : 4'hF;
        fetched.rB    = needRegids ? regByte[3:0] : 4'hF;
        fetched.valC  = valC;
        fetched.valP  = f_pc + 32'(len);
        if (memErr) begin
            fetched.stat  = STAT_ADR;
            fetched.icode = 4'h1;
            fetched.ifun  = 4'h0;
            fetched.rA    = 4'hF;
            fetched.rB    = 4'hF;
            fetched.valC  = 32'h0;
        end else if (icode >= 4'hC) begin
            fetched.stat = STAT_INS;
        end else if (icode == 4'h0) begin
            fetched.stat = STAT_HLT;
        end
    end

    // A faulting or halting instruction pins fetch on itself.
    always_comb begin
        if (fetched.stat != STAT_AOK)
            predNext = f_pc;
        else if (icode == 4'h7 || icode == 4'h8)
            predNext = valC;
        else
            predNext = fetched.valP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            predPC <= RESET_PC;
        else if (!stall_f)
            predPC <= predNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fd <= BUBBLE;
        else if (bubble_d)
            fd <= BUBBLE;
        else if (!stall_d)
            fd <= fetched;
    end

    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_LIMIT))
            imem[imem_waddr[AW-1:0]] <= imem_wdata;
    end

    assign D_stat  = fd.stat;
    assign D_icode = fd.icode;
    assign D_ifun  = fd.ifun;
    assign D_rA    = fd.rA;
    assign D_rB    = fd.rB;
    assign D_valC  = fd.valC;
    assign D_valP  = fd.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed program scenarios plus random traffic,
// checked each cycle against an instruction-level fetch model.
module tb_fetch_stage;

    localparam int IMEM = 1024;
    localparam logic [31:0] RPC_B = 32'(IMEM - 2);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemWe = 1'b0;
    logic [31:0] imemWaddr = '0;
    logic [7:0]  imemWdata = '0;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        bubbleD = 1'b0;
    logic        mispred = 1'b0;
    logic [31:0] mispredPc = '0;
    logic        retDone = 1'b0;
    logic [31:0] retPc = '0;

    logic [31:0] fPcA, valCA, valPA, fPcB, valCB, valPB;
    logic [2:0]  statA, statB;
    logic [3:0]  icodeA, ifunA, rAA, rBA, icodeB, ifunB, rAB, rBB;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.IMEM_BYTES(IMEM), .RESET_PC(32'h0)) dutA (
        .clk(clk), .reset(reset),
        .imem_we(imemWe), .imem_waddr(imemWaddr), .imem_wdata(imemWdata),
        .stall_f(stallF), .stall_d(stallD), .bubble_d(bubbleD),
        .mispred(mispred), .mispred_pc(mispredPc),
        .ret_done(retDone), .ret_pc(retPc),
        .f_pc(fPcA), .D_stat(statA), .D_icode(icodeA), .D_ifun(ifunA),
        .D_rA(rAA), .D_rB(rBA), .D_valC(valCA), .D_valP(valPA)
    );

    fetch_stage #(.IMEM_BYTES(IMEM), .RESET_PC(RPC_B)) dutB (
        .clk(clk), .reset(reset),
        .imem_we(imemWe), .imem_waddr(imemWaddr), .imem_wdata(imemWdata),
        .stall_f(stallF), .stall_d(stallD), .bubble_d(bubbleD),
        .mispred(mispred), .mispred_pc(mispredPc),
        .ret_done(retDone), .ret_pc(retPc),
        .f_pc(fPcB), .D_stat(statB), .D_icode(icodeB), .D_ifun(ifunB),
        .D_rA(rAB), .D_rB(rBB), .D_valC(valCB), .D_valP(valPB)
    );

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [31:0] valC;
        logic [31:0] valP;
        logic [31:0] next;
    } fetchT;

    logic [7:0]  memModel [IMEM];
    logic [31:0] predA, predB;
    fetchT       dA, dB, fetchA, fetchB;

    function automatic logic [7:0] readMem(input longint a);
        if (a < 0 || a >= IMEM)
            return 8'h00;
        return memModel[int'(a)];
    endfunction

    function automatic fetchT bubbleVal();
        fetchT r;
        r.stat = 3'd1; r.icode = 4'h1; r.ifun = 4'h0;
        r.rA = 4'hF; r.rB = 4'hF;
        r.valC = 32'h0; r.valP = 32'h0; r.next = 32'h0;
        return r;
    endfunction

    // Instruction-level view: size the instruction, then check every byte.
    function automatic fetchT fetchModel(input logic [31:0] pc);
        fetchT r;
        logic [7:0] b0, rb;
        bit regs, cst, bad;
        int len;
        longint base;
        base = longint'(pc);
        b0 = readMem(base);
        r.icode = b0[7:4];
        r.ifun = b0[3:0];
        regs = r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cst = r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        len = 1 + (regs ? 1 : 0) + (cst ? 4 : 0);
        bad = 1'b0;
        for (int i = 0; i < len; i++)
            if (base + i >= IMEM) bad = 1'b1;
        rb = readMem(base + 1);
        r.rA = regs ? rb[7:4] : 4'hF;
        r.rB = regs ? rb[3:0] : 4'hF;
        r.valC = 32'h0;
        if (cst)
            for (int k = 0; k < 4; k++)
                r.valC[8*k +: 8] = readMem(base + 1 + (regs ? 1 : 0) + k);
        r.valP = pc + 32'(len);
        if (bad) begin
            r.stat = 3'd3; r.icode = 4'h1; r.ifun = 4'h0;
            r.rA = 4'hF; r.rB = 4'hF; r.valC = 32'h0;
        end else if (r.icode >= 4'hC) r.stat = 3'd4;
        else if (r.icode == 4'h0) r.stat = 3'd2;
        else r.stat = 3'd1;
        if (r.stat != 3'd1) r.next = pc;
        else if (r.icode == 4'h7 || r.icode == 4'h8) r.next = r.valC;
        else r.next = r.valP;
        return r;
    endfunction

    function automatic logic [31:0] selPc(input logic [31:0] p, input logic mp,
                                          input logic [31:0] mpc, input logic rd,
                                          input logic [31:0] rpc);
        return mp ? mpc : (rd ? rpc : p);
    endfunction

    always_comb fetchA = fetchModel(selPc(predA, mispred, mispredPc, retDone, retPc));
    always_comb fetchB = fetchModel(selPc(predB, mispred, mispredPc, retDone, retPc));

    always @(posedge clk) begin
        if (imemWe && imemWaddr < 32'(IMEM))
            memModel[imemWaddr[9:0]] <= imemWdata;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            predA <= 32'h0;
            predB <= RPC_B;
            dA <= bubbleVal();
            dB <= bubbleVal();
        end else begin
            if (!stallF) begin
                predA <= fetchA.next;
                predB <= fetchB.next;
            end
            if (bubbleD) begin
                dA <= bubbleVal();
                dB <= bubbleVal();
            end else if (!stallD) begin
                dA <= fetchA;
                dB <= fetchB;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("A.f_pc", fPcA, selPc(predA, mispred, mispredPc, retDone, retPc));
        chk("A.D_stat", 32'(statA), 32'(dA.stat));
        chk("A.D_icode", 32'(icodeA), 32'(dA.icode));
        chk("A.D_ifun", 32'(ifunA), 32'(dA.ifun));
        chk("A.D_rA", 32'(rAA), 32'(dA.rA));
        chk("A.D_rB", 32'(rBA), 32'(dA.rB));
        chk("A.D_valC", valCA, dA.valC);
        chk("A.D_valP", valPA, dA.valP);
        chk("B.f_pc", fPcB, selPc(predB, mispred, mispredPc, retDone, retPc));
        chk("B.D_stat", 32'(statB), 32'(dB.stat));
        chk("B.D_icode", 32'(icodeB), 32'(dB.icode));
        chk("B.D_valC", valCB, dB.valC);
        chk("B.D_valP", valPB, dB.valP);
    end

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        imemWe = 1'b1;
        imemWaddr = a;
        imemWdata = d;
        @(posedge clk);
        #2;
        imemWe = 1'b0;
    endtask

    task automatic nextNeg();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randPc();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, IMEM - 1));
            1: return 32'($urandom_range(IMEM - 8, IMEM - 1));
            2: return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    logic [7:0] prog [11];
    logic [3:0] ic;

    initial begin
        prog = '{8'h30, 8'hF3, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'h70, 8'h00, 8'h01, 8'h00, 8'h00};
        @(posedge clk);
        #2;
        for (int a = 0; a < IMEM; a++) wr(32'(a), 8'h00);
        for (int a = 0; a < 11; a++) wr(32'(a), prog[a]);
        wr(32'(IMEM - 2), 8'h30);
        wr(32'(IMEM - 1), 8'hF3);
        wr(32'(IMEM), 8'hAA);
        wr(32'hFFFF_FFFF, 8'hBB);

        // reset state
        #1;
        chk("rst.D_icode", 32'(icodeA), 32'h1);
        chk("rst.D_stat", 32'(statA), 32'h1);
        chk("rst.D_rA", 32'(rAA), 32'hF);
        chk("rst.D_valP", valPA, 32'h0);
        chk("rst.B.f_pc", fPcB, 32'(IMEM - 2));
        reset = 1'b0;
        #1;
        chk("rst.f_pc", fPcA, 32'h0);

        // irmovl at 0; dutB irmovl straddling the end of memory
        nextNeg();
        chk("t1.D_icode", 32'(icodeA), 32'h3);
        chk("t1.D_rA", 32'(rAA), 32'hF);
        chk("t1.D_rB", 32'(rBA), 32'h3);
        chk("t1.D_valC", valCA, 32'h1234_5678);
        chk("t1.D_valP", valPA, 32'h6);
        chk("t1.D_stat", 32'(statA), 32'h1);
        chk("t1.f_pc", fPcA, 32'h6);
        chk("t5.B.D_stat", 32'(statB), 32'h3);
        chk("t5.B.D_icode", 32'(icodeB), 32'h1);
        chk("t5.B.D_valC", valCB, 32'h0);
        chk("t5.B.f_pc", fPcB, 32'(IMEM - 2));

        // stall then bubble
        #1;
        stallF = 1'b1;
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextNeg();
            chk("t3.f_pc", fPcA, 32'h6);
            chk("t3.D_icode", 32'(icodeA), 32'h3);
            chk("t3.D_valC", valCA, 32'h1234_5678);
            chk("t3.D_valP", valPA, 32'h6);
        end
        #1;
        bubbleD = 1'b1;
        nextNeg();
        chk("t3.bub.D_icode", 32'(icodeA), 32'h1);
        chk("t3.bub.D_rA", 32'(rAA), 32'hF);
        chk("t3.bub.D_stat", 32'(statA), 32'h1);
        chk("t3.bub.f_pc", fPcA, 32'h6);
        #1;
        stallF = 1'b0;
        stallD = 1'b0;
        bubbleD = 1'b0;

        // jmp 0x100, then redirect
        nextNeg();
        chk("t2.D_icode", 32'(icodeA), 32'h7);
        chk("t2.D_valC", valCA, 32'h100);
        chk("t2.D_valP", valPA, 32'hB);
        chk("t2.f_pc", fPcA, 32'h100);
        #1;
        mispred = 1'b1;
        mispredPc = 32'hB;
        #1;
        chk("t2.mp.f_pc", fPcA, 32'hB);
        retDone = 1'b1;
        retPc = 32'h40;
        #1;
        chk("t2.both.f_pc", fPcA, 32'hB);
        mispred = 1'b0;
        #1;
        chk("t2.ret.f_pc", fPcA, 32'h40);
        retDone = 1'b0;
        mispred = 1'b1;
        nextNeg();
        chk("t2.hlt.D_stat", 32'(statA), 32'h2);
        chk("t2.hlt.D_valP", valPA, 32'hC);
        #1;
        mispred = 1'b0;
        nextNeg();
        chk("t2.hold.f_pc", fPcA, 32'hB);

        // invalid opcode at 0
        #1;
        wr(32'h0, 8'hC0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        nextNeg();
        chk("t4.D_stat", 32'(statA), 32'h4);
        chk("t4.D_icode", 32'(icodeA), 32'hC);
        chk("t4.f_pc", fPcA, 32'h0);
        nextNeg();
        chk("t4.hold.f_pc", fPcA, 32'h0);

        // write-while-fetch, halt, async reset mid-cycle
        #1;
        imemWe = 1'b1;
        imemWaddr = 32'h0;
        imemWdata = 8'h00;
        nextNeg();
        chk("t6.old.D_stat", 32'(statA), 32'h4);
        #1;
        imemWe = 1'b0;
        nextNeg();
        chk("t6.D_stat", 32'(statA), 32'h2);
        chk("t6.f_pc", fPcA, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("t6.rst.D_stat", 32'(statA), 32'h1);
        chk("t6.rst.D_icode", 32'(icodeA), 32'h1);
        chk("t6.rst.D_rB", 32'(rBA), 32'hF);
        chk("t6.rst.f_pc", fPcA, 32'h0);
        chk("t6.rst.B.f_pc", fPcB, 32'(IMEM - 2));
        #1;

        // random program and control traffic
        for (int a = 0; a < IMEM; a++) begin
            ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 11));
            wr(32'(a), {ic, 4'($urandom_range(0, 15))});
        end
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            reset = ($urandom_range(0, 99) == 0);
            stallF = ($urandom_range(0, 99) < 15);
            stallD = ($urandom_range(0, 99) < 15);
            bubbleD = ($urandom_range(0, 99) < 10);
            mispred = ($urandom_range(0, 99) < 10);
            mispredPc = randPc();
            retDone = ($urandom_range(0, 99) < 10);
            retPc = randPc();
            imemWe = ($urandom_range(0, 99) < 20);
            imemWaddr = 32'($urandom_range(0, IMEM + 64));
            imemWdata = 8'($urandom);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        imemWe = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
